store_checker: RTL and testbench

Parametrised self-checking monitor for the rv32i data-memory write port. It holds a programmed list of up to DEPTH expected stores and compares each observed write, in order, against that list. It reports pass, fail or timeout with the failing index and value. Instantiated beside `memory_inst` so directed programs (loops, branches, continues) are checked in hardware rather than by a single value sampled at a fixed time.

---
 rtl/store_checker.sv | 219 +++++++++++++++++++++
 tb/tb_store_checker.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_checker.sv
// rtl/store_checker.sv - in-order checker for data-memory stores against a programmed list
//
// Purpose: holds up to DEPTH expected stores loaded through a valid/ready port,
// then, once armed, compares every memory write in order against that list and
// reports pass, mismatch fail or timeout fail with the failing index and data.
//
// Optional feature macro: STORE_CHECK_ADDR_EN
//   defined   - entries also store exp_addr and a write must match data and address
//   undefined - only data is compared; exp_addr/mon_addr are unused
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   exp_valid/exp_ready       expected-entry handshake (IDLE only)
//   exp_data, exp_addr        expected entry contents
//   arm                       one-cycle pulse starting a check run
//   tmo_cycles                run timeout in cycles, 0 disables it
//   mon_write/addr/data       observed memory write port
//   busy, done                run in progress / run finished (held)
//   pass, fail, timeout       run result, valid while done
//   fail_index, fail_data     failing entry index and observed data (0 on timeout)
//   match_count               stores matched in the current run

module store_checker #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8,
  parameter int TMO_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       exp_valid,
  output logic                       exp_ready,
  input  logic [DATA_W-1:0]          exp_data,
  input  logic [ADDR_W-1:0]          exp_addr,
  input  logic                       arm,
  input  logic [TMO_W-1:0]           tmo_cycles,
  input  logic                       mon_write,
  input  logic [ADDR_W-1:0]          mon_addr,
  input  logic [DATA_W-1:0]          mon_data,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [$clog2(DEPTH)-1:0]   fail_index,
  output logic [DATA_W-1:0]          fail_data,
  output logic [$clog2(DEPTH+1)-1:0] match_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     match_q, match_d;
  logic [TMO_W-1:0]  cyc_q, cyc_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              tmo_q, tmo_d;
  logic [PW-1:0]     fidx_q, fidx_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;

  logic [DATA_W-1:0] entry_data_q [DEPTH];

  logic accept;
  logic entry_hit;
  logic last_entry;
  logic tmo_hit;

  // Ready is a pure decode of registered state, so it changes only on clock edges.
  assign exp_ready = (state_q == S_IDLE) && (count_q < CW'(DEPTH));
  assign accept    = exp_valid && exp_ready;

`ifdef STORE_CHECK_ADDR_EN
  logic [ADDR_W-1:0] entry_addr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (accept) begin
      entry_addr_q[count_q[PW-1:0]] <= exp_addr;
    end
  end

  assign entry_hit = (mon_data == entry_data_q[rd_ptr_q]) &&
                     (mon_addr == entry_addr_q[rd_ptr_q]);
`else
  logic unused_addr;
  assign unused_addr = ^{exp_addr, mon_addr};
  assign entry_hit   = (mon_data == entry_data_q[rd_ptr_q]);
`endif

  // The list is never cleared in place; resetting count empties it logically.
  always_ff @(posedge clk) begin
    if (accept) begin
      entry_data_q[count_q[PW-1:0]] <= exp_data;
    end
  end

  assign last_entry = (CW'(rd_ptr_q) == (count_q - CW'(1)));
  assign tmo_hit    = (tmo_cycles != '0) && (cyc_q == (tmo_cycles - TMO_W'(1)));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    match_d  = match_q;
    cyc_d    = cyc_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    tmo_d    = tmo_q;
    fidx_d   = fidx_q;
    fdata_d  = fdata_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          count_d = count_q + CW'(1);
        end
        if (arm && (count_q != '0)) begin
          state_d  = S_RUN;
          rd_ptr_d = '0;
          match_d  = '0;
          cyc_d    = '0;
        end
      end

      S_RUN: begin
        cyc_d = cyc_q + TMO_W'(1);
        if (mon_write && !entry_hit) begin
          // A completing compare beats a timeout on the same cycle.
          state_d = S_DONE;
          fail_d  = 1'b1;
          fidx_d  = rd_ptr_q;
          fdata_d = mon_data;
        end else if (mon_write) begin
          match_d = match_q + CW'(1);
          if (last_entry) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (tmo_hit) begin
              // The match is kept; the entry that never arrived is the next one.
              state_d = S_DONE;
              fail_d  = 1'b1;
              tmo_d   = 1'b1;
              fidx_d  = rd_ptr_q + PW'(1);
              fdata_d = '0;
            end
          end
        end else if (tmo_hit) begin
          state_d = S_DONE;
          fail_d  = 1'b1;
          tmo_d   = 1'b1;
          fidx_d  = rd_ptr_q;
          fdata_d = '0;
        end
      end

      S_DONE: begin
        if (arm) begin
          state_d  = S_RUN;
          rd_ptr_d = '0;
          match_d  = '0;
          cyc_d    = '0;
          pass_d   = 1'b0;
          fail_d   = 1'b0;
          tmo_d    = 1'b0;
          fidx_d   = '0;
          fdata_d  = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      match_q  <= '0;
      cyc_q    <= '0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      tmo_q    <= 1'b0;
      fidx_q   <= '0;
      fdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      match_q  <= match_d;
      cyc_q    <= cyc_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      tmo_q    <= tmo_d;
      fidx_q   <= fidx_d;
      fdata_q  <= fdata_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = tmo_q;
  assign fail_index  = fidx_q;
  assign fail_data   = fdata_q;
  assign match_count = match_q;

endmodule

// File: tb/tb_store_checker.sv
// tb/tb_store_checker.sv - scoreboard bench for store_checker

module tb_store_checker;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam int TMO_W  = 16;

  logic              clk;
  logic              rst;
  logic              exp_valid;
  logic              exp_ready;
  logic [DATA_W-1:0] exp_data;
  logic [ADDR_W-1:0] exp_addr;
  logic              arm;
  logic [TMO_W-1:0]  tmo_cycles;
  logic              mon_write;
  logic [ADDR_W-1:0] mon_addr;
  logic [DATA_W-1:0] mon_data;
  logic              busy;
  logic              done;
  logic              pass;
  logic              fail;
  logic              timeout;
  logic [1:0]        fail_index;
  logic [DATA_W-1:0] fail_data;
  logic [2:0]        match_count;

  store_checker #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .TMO_W (TMO_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .exp_valid  (exp_valid),
    .exp_ready  (exp_ready),
    .exp_data   (exp_data),
    .exp_addr   (exp_addr),
    .arm        (arm),
    .tmo_cycles (tmo_cycles),
    .mon_write  (mon_write),
    .mon_addr   (mon_addr),
    .mon_data   (mon_data),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout),
    .fail_index (fail_index),
    .fail_data  (fail_data),
    .match_count(match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        p;
    logic        f;
    logic        t;
    logic [1:0]  idx;
    logic [31:0] data;
    logic [2:0]  mc;
  } result_t;

  result_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_result(input logic p, input logic f, input logic t,
                               input logic [1:0] idx, input logic [31:0] data,
                               input logic [2:0] mc);
    result_t r;
    r.p = p; r.f = f; r.t = t; r.idx = idx; r.data = data; r.mc = mc;
    sb.push_back(r);
  endtask

  // Monitor: every rising done pops one expected result and compares it.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      done_prev = 1'b0;
    end else begin
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got a result with no expectation queued");
        end else begin
          result_t e;
          e = sb.pop_front();
          chk("res_pass",        64'(pass),        64'(e.p));
          chk("res_fail",        64'(fail),        64'(e.f));
          chk("res_timeout",     64'(timeout),     64'(e.t));
          chk("res_fail_index",  64'(fail_index),  64'(e.idx));
          chk("res_fail_data",   64'(fail_data),   64'(e.data));
          chk("res_match_count", 64'(match_count), 64'(e.mc));
        end
      end
      done_prev = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [31:0] d, input logic [31:0] a);
    exp_valid = 1'b1;
    exp_data  = d;
    exp_addr  = a;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d, input logic [31:0] a);
    mon_write = 1'b1;
    mon_data  = d;
    mon_addr  = a;
    tick();
    mon_write = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_done_in_time"}, 64'(done), 64'(1));
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    exp_valid  = 1'b0;
    exp_data   = '0;
    exp_addr   = '0;
    arm        = 1'b0;
    tmo_cycles = '0;
    mon_write  = 1'b0;
    mon_addr   = '0;
    mon_data   = '0;
    tick();
    tick();

    chk("rst_busy",        64'(busy),        64'(0));
    chk("rst_done",        64'(done),        64'(0));
    chk("rst_pass",        64'(pass),        64'(0));
    chk("rst_fail",        64'(fail),        64'(0));
    chk("rst_timeout",     64'(timeout),     64'(0));
    chk("rst_fail_index",  64'(fail_index),  64'(0));
    chk("rst_fail_data",   64'(fail_data),   64'(0));
    chk("rst_match_count", 64'(match_count), 64'(0));
    rst = 1'b0;
    tick();
    chk("rst_exp_ready", 64'(exp_ready), 64'(1));

    // Single entry, write of 12 arriving at run cycle 5.
    reset_dut();
    load(32'd12, 32'h0);
    arm_pulse();
    chk("t1_busy_after_arm", 64'(busy), 64'(1));
    repeat (4) tick();
    expect_result(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 3'd1);
    wr(32'd12, 32'h0);
    chk("t1_done_next_edge", 64'(done), 64'(1));
    chk("t1_busy_cleared",   64'(busy), 64'(0));
    wait_done("t1", 5);

    // Mismatch on the third store.
    reset_dut();
    load(32'd3, 32'h0);
    load(32'd7, 32'h0);
    load(32'd12, 32'h0);
    arm_pulse();
    expect_result(1'b0, 1'b1, 1'b0, 2'd2, 32'd9, 3'd2);
    wr(32'd3, 32'h0);
    wr(32'd7, 32'h0);
    wr(32'd9, 32'h0);
    wait_done("t2", 5);

    // Timeout of 20 after one of two matches.
    reset_dut();
    tmo_cycles = 16'd20;
    load(32'd5, 32'h0);
    load(32'd6, 32'h0);
    arm_pulse();
    expect_result(1'b0, 1'b1, 1'b1, 2'd1, 32'd0, 3'd1);
    wr(32'd5, 32'h0);
    repeat (18) tick();
    chk("t3_not_done_before_tmo", 64'(done), 64'(0));
    tick();
    chk("t3_done_at_tmo", 64'(done), 64'(1));
    wait_done("t3", 5);
    tmo_cycles = '0;

    // Empty-list arm, fill beyond DEPTH, final match on the timeout cycle.
    reset_dut();
    arm_pulse();
    chk("t4_arm_empty_busy",  64'(busy),      64'(0));
    chk("t4_arm_empty_ready", 64'(exp_ready), 64'(1));
    for (int i = 0; i < DEPTH + 1; i++) begin
      exp_valid = 1'b1;
      exp_data  = 32'(10 + i);
      exp_addr  = '0;
      chk($sformatf("t4_ready_%0d", i), 64'(exp_ready), 64'((i < DEPTH) ? 1 : 0));
      tick();
    end
    exp_valid = 1'b0;
    chk("t4_ready_full", 64'(exp_ready), 64'(0));
    tmo_cycles = 16'd4;
    arm_pulse();
    expect_result(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 3'd4);
    wr(32'd10, 32'h0);
    wr(32'd11, 32'h0);
    wr(32'd12, 32'h0);
    wr(32'd13, 32'h0);
    wait_done("t4_pass", 5);

    // Rerun from DONE: mismatch on the timeout cycle reports a data failure.
    tmo_cycles = 16'd2;
    arm_pulse();
    chk("t4_rerun_done_clr",  64'(done),        64'(0));
    chk("t4_rerun_pass_clr",  64'(pass),        64'(0));
    chk("t4_rerun_mc_clr",    64'(match_count), 64'(0));
    expect_result(1'b0, 1'b1, 1'b0, 2'd1, 32'd99, 3'd1);
    wr(32'd10, 32'h0);
    wr(32'd99, 32'h0);
    wait_done("t4_tmo_mismatch", 5);
    tmo_cycles = '0;

    // Reset mid-run, then rerun the same list twice.
    reset_dut();
    load(32'd1, 32'h0);
    load(32'd2, 32'h0);
    load(32'd3, 32'h0);
    arm_pulse();
    wr(32'd1, 32'h0);
    chk("t5_mc_before_rst", 64'(match_count), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_busy",  64'(busy),        64'(0));
    chk("t5_rst_mc",    64'(match_count), 64'(0));
    chk("t5_rst_ready", 64'(exp_ready),   64'(1));
    load(32'd1, 32'h0);
    load(32'd2, 32'h0);
    load(32'd3, 32'h0);
    arm_pulse();
    expect_result(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 3'd3);
    wr(32'd1, 32'h0);
    wr(32'd2, 32'h0);
    wr(32'd3, 32'h0);
    wait_done("t5_run1", 5);
    arm_pulse();
    chk("t5_rearm_done", 64'(done), 64'(0));
    chk("t5_rearm_pass", 64'(pass), 64'(0));
    chk("t5_rearm_busy", 64'(busy), 64'(1));
    expect_result(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 3'd3);
    wr(32'd1, 32'h0);
    wr(32'd2, 32'h0);
    wr(32'd3, 32'h0);
    wait_done("t5_run2", 5);

    // Address compare, present only with the optional feature.
    reset_dut();
    load(32'd12, 32'h40);
    arm_pulse();
`ifdef STORE_CHECK_ADDR_EN
    expect_result(1'b0, 1'b1, 1'b0, 2'd0, 32'd12, 3'd0);
`else
    expect_result(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 3'd1);
`endif
    wr(32'd12, 32'h44);
    wait_done("t6", 5);

    tick();
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
